swipt_duty_modulator: RTL and testbench

Parametrised duty-cycle modulator for the SWIPT power transmitter. It sits between the duty-cycle command source (`l`) and the PWM generator. In data-write mode it encodes the serial `data` line onto the carrier: each data edge triggers a fixed-length saturation burst, followed by a settled per-bit duty level. The block synchronises `data` into the `clk` domain and runs an explicit burst FSM with abort, restart and status outputs.

---
 rtl/swipt_duty_modulator_if.sv | 33 +++
 rtl/swipt_duty_modulator.sv | 153 +++++++++++++++
 tb/tb_swipt_duty_modulator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/swipt_duty_modulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : swipt_duty_modulator_if
//  Description : Control/data bundle between the SWIPT transmitter control
//                logic (master) and the duty-cycle modulator (slave).
//                master drives: swipt_alive, mode, read, write, data, l
//                slave drives : duty_cycle, hold_active, bit_done
//  Revision    : 1.0 - initial release
// ============================================================================
interface swipt_duty_modulator_if #(
    parameter int DW = 12
);
    logic          swipt_alive;  // link-alive qualifier, low = soft reset
    logic [1:0]    mode;         // 3 = modulation enabled
    logic          read;         // receive phase, blocks modulation
    logic          write;        // transmit phase
    logic          data;         // asynchronous serial bit line
    logic [DW-1:0] l;            // nominal duty command
    logic [DW-1:0] duty_cycle;   // registered duty output
    logic          hold_active;  // burst currently on the output
    logic          bit_done;     // first settled cycle after a burst

    modport master (
        output swipt_alive, mode, read, write, data, l,
        input  duty_cycle, hold_active, bit_done
    );

    modport slave (
        input  swipt_alive, mode, read, write, data, l,
        output duty_cycle, hold_active, bit_done
    );
endinterface
`default_nettype wire

// File: rtl/swipt_duty_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : swipt_duty_modulator
//  Description : Duty-cycle modulator for the SWIPT power transmitter.
//                Synchronises the serial data line, turns every data edge
//                into a fixed-length saturation burst (DUTY_MAX after a
//                falling edge, 0 after a rising edge) and then outputs a
//                settled per-bit level derived from the clamped command.
//  Ports       : clk  - clock
//                nrst - synchronous active-low reset
//                bus  - swipt_duty_modulator_if.slave (controls, data, l,
//                       duty_cycle, hold_active, bit_done)
//  Revision    : 1.0 - initial release
// ============================================================================
module swipt_duty_modulator #(
    parameter int DW          = 12,
    parameter int DUTY_MAX    = 500,
    parameter int HOLD_CYCLES = 12288,
    parameter int CW          = 20
) (
    input  wire logic              clk,
    input  wire logic              nrst,
    swipt_duty_modulator_if.slave  bus
);

    localparam logic [DW+1:0] c_DMAX      = (DW+2)'(DUTY_MAX);
    localparam logic [DW-1:0] c_DMAX_OUT  = DW'(DUTY_MAX);
    localparam bit            c_NO_BURST  = (HOLD_CYCLES == 0);
    localparam logic [CW-1:0] c_HOLD_LOAD = c_NO_BURST ? '0 : CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PASS     = 2'd0,
        ST_SETTLED  = 2'd1,
        ST_BURST_HI = 2'd2,
        ST_BURST_LO = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Data synchroniser; only nrst clears it so edge history survives a
    // link drop and recovery does not see a stale edge.
    // ------------------------------------------------------------------
    logic r_sync1, r_data_s, r_data_d;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync1  <= 1'b0;
            r_data_s <= 1'b0;
            r_data_d <= 1'b0;
        end else begin
            r_sync1  <= bus.data;
            r_data_s <= r_sync1;
            r_data_d <= r_data_s;
        end
    end

    logic w_rise, w_fall, w_edge, w_en;
    assign w_rise = r_data_s & ~r_data_d;
    assign w_fall = ~r_data_s & r_data_d;
    assign w_edge = w_rise | w_fall;
    assign w_en   = (bus.mode == 2'd3) & bus.write & ~bus.read;

    // ------------------------------------------------------------------
    // Level computation in DW+2 bits so lc + lc/2 and 2*lc cannot wrap.
    // ------------------------------------------------------------------
    logic [DW+1:0] w_l_ext, w_lc, w_l0, w_l1, w_settled;
    logic [DW+1:0] w_s2, w_s3, w_s4;

    assign w_l_ext = {2'b00, bus.l};
    assign w_lc    = (w_l_ext > c_DMAX) ? c_DMAX : w_l_ext;
    assign w_s2    = w_lc + w_lc / 2;
    assign w_s3    = w_lc + w_lc / 3;
    assign w_s4    = w_lc + w_lc / 4;

    always_comb begin
        w_l0 = c_DMAX;
        if (w_s2 < c_DMAX)      w_l0 = w_s2;
        else if (w_s3 < c_DMAX) w_l0 = w_s3;
        else if (w_s4 < c_DMAX) w_l0 = w_s4;
    end

    // Near full scale, mirror around DUTY_MAX to keep the two levels apart.
    assign w_l1      = ((c_DMAX - w_lc) < (w_lc / 5)) ? ((w_lc << 1) - c_DMAX) : (w_lc / 3);
    assign w_settled = r_data_s ? w_l1 : w_l0;

    // All values are bounded by DUTY_MAX, so the two guard bits are always 0.
    logic w_unused_guard;
    assign w_unused_guard = ^{w_lc[DW+1:DW], w_settled[DW+1:DW]};

    // ------------------------------------------------------------------
    // Burst FSM with registered outputs
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_duty;
    logic          r_hold;
    logic          r_bit_done;

    always_ff @(posedge clk) begin
        if (!nrst || !bus.swipt_alive) begin
            r_state    <= ST_PASS;
            r_cnt      <= '0;
            r_duty     <= '0;
            r_hold     <= 1'b0;
            r_bit_done <= 1'b0;
        end else if (!w_en) begin
            r_state    <= ST_PASS;
            r_cnt      <= '0;
            r_duty     <= w_lc[DW-1:0];
            r_hold     <= 1'b0;
            r_bit_done <= 1'b0;
        end else if (w_edge) begin
            if (c_NO_BURST) begin
                r_state    <= ST_SETTLED;
                r_cnt      <= '0;
                r_duty     <= w_settled[DW-1:0];
                r_hold     <= 1'b0;
                r_bit_done <= 1'b1;
            end else begin
                // A new edge always (re)starts a burst with its own polarity.
                r_state    <= w_fall ? ST_BURST_HI : ST_BURST_LO;
                r_cnt      <= c_HOLD_LOAD;
                r_duty     <= w_fall ? c_DMAX_OUT : '0;
                r_hold     <= 1'b1;
                r_bit_done <= 1'b0;
            end
        end else begin
            r_bit_done <= 1'b0;
            case (r_state)
                ST_PASS, ST_SETTLED: begin
                    r_state <= ST_SETTLED;
                    r_duty  <= w_settled[DW-1:0];
                    r_hold  <= 1'b0;
                end
                default: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_SETTLED;
                        r_duty     <= w_settled[DW-1:0];
                        r_hold     <= 1'b0;
                        r_bit_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.duty_cycle  = r_duty;
    assign bus.hold_active = r_hold;
    assign bus.bit_done    = r_bit_done;

endmodule
`default_nettype wire

// File: tb/tb_swipt_duty_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swipt_duty_modulator
//  Description : Directed self-checking bench for swipt_duty_modulator with
//                HOLD_CYCLES = 8, DUTY_MAX = 500, DW = 12.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swipt_duty_modulator;

    localparam int DW = 12;

    logic clk;
    logic nrst;

    swipt_duty_modulator_if #(.DW(DW)) bus ();

    swipt_duty_modulator #(
        .DW          (DW),
        .DUTY_MAX    (500),
        .HOLD_CYCLES (8),
        .CW          (20)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] duty;
        logic          hold;
        logic          done;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    // Push the expected output for each of the next n cycles, advance one
    // clock per entry and compare once the registered output has settled.
    task automatic step(input int n, input logic [DW-1:0] d, input logic h,
                        input logic b, input string tag);
        exp_t e;
        exp_t got;
        for (int i = 0; i < n; i++) begin
            e.duty = d; e.hold = h; e.done = b; e.tag = tag;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            tests++;
            assert ({bus.duty_cycle, bus.hold_active, bus.bit_done} ===
                    {got.duty, got.hold, got.done})
            else begin
                failed++;
                $error("FAIL %s[%0d]: observed duty=%0d hold=%0b done=%0b, expected duty=%0d hold=%0b done=%0b",
                       got.tag, i, bus.duty_cycle, bus.hold_active, bus.bit_done,
                       got.duty, got.hold, got.done);
            end
        end
    endtask

    initial begin
        nrst = 1'b0;
        bus.swipt_alive = 1'b1;
        bus.mode  = 2'd0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.data  = 1'b0;
        bus.l     = 12'd0;

        // Reset state
        step(2, 0, 0, 0, "reset");
        nrst = 1'b1;

        // Pass-through and clamp
        bus.write = 1'b1; bus.l = 12'd200;
        step(1, 200, 0, 0, "pass_200");
        bus.l = 12'd600;
        step(1, 500, 0, 0, "pass_clamp");

        // Settled level ZERO
        bus.mode = 2'd3; bus.l = 12'd200;
        step(1, 300, 0, 0, "l0_200");
        bus.l = 12'd400;
        step(1, 500, 0, 0, "l0_400");

        // write low keeps pass-through even in mode 3
        bus.write = 1'b0; bus.l = 12'd200;
        step(1, 200, 0, 0, "no_write");

        // Move data to 1 while disabled: no burst afterwards
        bus.mode = 2'd0; bus.write = 1'b1; bus.data = 1'b1;
        step(3, 200, 0, 0, "pass_data_change");
        bus.mode = 2'd3;
        step(1, 66, 0, 0, "l1_200");
        bus.l = 12'd450;
        step(1, 400, 0, 0, "l1_450");
        bus.l = 12'd200;
        step(1, 66, 0, 0, "l1_back");

        // Falling edge: DUTY_MAX burst then level ZERO
        bus.data = 1'b0;
        step(2, 66, 0, 0, "fall_latency");
        step(8, 500, 1, 0, "burst_hi");
        step(1, 300, 0, 1, "done_hi");
        step(1, 300, 0, 0, "settled_l0");

        // Rising edge: zero burst then level ONE
        bus.data = 1'b1;
        step(2, 300, 0, 0, "rise_latency");
        step(8, 0, 1, 0, "burst_lo");
        step(1, 66, 0, 1, "done_lo");
        step(1, 66, 0, 0, "settled_l1");

        // Restart: rising burst cut short by a falling edge
        bus.mode = 2'd0; bus.data = 1'b0;
        step(3, 200, 0, 0, "pass_prep");
        bus.mode = 2'd3;
        step(1, 300, 0, 0, "restart_prep");
        bus.data = 1'b1;
        step(2, 300, 0, 0, "restart_latency");
        step(4, 0, 1, 0, "restart_lo_a");
        bus.data = 1'b0;
        step(2, 0, 1, 0, "restart_lo_b");
        step(8, 500, 1, 0, "restart_hi");
        step(1, 300, 0, 1, "restart_done");
        step(2, 300, 0, 0, "restart_settled");

        // Abort by read mid-burst
        bus.data = 1'b1;
        step(2, 300, 0, 0, "abort_latency");
        step(3, 0, 1, 0, "abort_burst");
        bus.read = 1'b1;
        step(3, 200, 0, 0, "abort");
        bus.read = 1'b0;
        step(2, 66, 0, 0, "abort_resume");

        // Reset mid-burst
        bus.data = 1'b0;
        step(2, 66, 0, 0, "rst_latency");
        step(3, 500, 1, 0, "rst_burst");
        nrst = 1'b0;
        step(1, 0, 0, 0, "rst_mid");
        nrst = 1'b1;
        step(2, 300, 0, 0, "rst_recover");

        // Link loss mid-burst
        bus.data = 1'b1;
        step(2, 300, 0, 0, "link_latency");
        step(3, 0, 1, 0, "link_burst");
        bus.swipt_alive = 1'b0;
        step(3, 0, 0, 0, "link_down");
        bus.swipt_alive = 1'b1;
        step(4, 66, 0, 0, "link_up");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
